// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - three-phase issue/capture sequencer for an external combinational ALU
//
// Purpose:
//   Accepts one command at a time, decodes it into ALU controls, gives the
//   external ALU one full cycle to settle, then captures the result and flags
//   into a small response FIFO. Illegal opcodes bypass the ALU and produce a
//   zero result tagged RspIllegal.
//   Optional feature macro: ALU_ISSUE_OVF_TRAP_EN (sticky OvfTrap on ADD/SUB
//   overflow; blocks further commands until reset).
//
// Ports:
//   Clock, Reset                 rising-edge clock, synchronous active-low reset
//   CmdValid/CmdReady            command handshake
//   CmdOp[2:0], CmdA, CmdB       opcode (0 AND,1 OR,2 ADD,3 SUB,4 NOR) and operands
//   AluA, AluB, AluAInvert, AluOp registered controls to the external ALU
//   AluResult, AluZero, AluOverflow, AluCarryOut  external ALU outputs
//   RspValid/RspReady            response handshake
//   RspResult, RspZero, RspOverflow, RspCarryOut, RspIllegal  head-of-FIFO payload
//   Busy                         FSM not idle or responses pending
//   OvfTrap                      sticky overflow trap (only with ALU_ISSUE_OVF_TRAP_EN)

module alu_issue_unit #(
  parameter int RESP_DEPTH = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [2:0]  CmdOp,
  input  logic [15:0] CmdA,
  input  logic [15:0] CmdB,
  output logic [15:0] AluA,
  output logic [15:0] AluB,
  output logic        AluAInvert,
  output logic [3:0]  AluOp,
  input  logic [15:0] AluResult,
  input  logic        AluZero,
  input  logic        AluOverflow,
  input  logic        AluCarryOut,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [15:0] RspResult,
  output logic        RspZero,
  output logic        RspOverflow,
  output logic        RspCarryOut,
  output logic        RspIllegal,
`ifdef ALU_ISSUE_OVF_TRAP_EN
  output logic        OvfTrap,
`endif
  output logic        Busy
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RESP_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RESP_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Entry layout: {result[15:0], zero, overflow, carry, illegal}
  logic [19:0]      mem [RESP_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             illegal_q;

  logic             accept, capture, pop, full, trap_active;
  logic [3:0]       dec_op;
  logic             dec_inv, dec_legal;
  logic [19:0]      push_data;

  always_comb begin
    dec_op    = 4'b0000;
    dec_inv   = 1'b0;
    dec_legal = 1'b1;
    case (CmdOp)
      3'd0:    dec_op = 4'b0000;
      3'd1:    dec_op = 4'b0001;
      3'd2:    dec_op = 4'b0100;
      3'd3:    dec_op = 4'b1100;
      3'd4: begin
        dec_op  = 4'b1000;
        dec_inv = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

`ifdef ALU_ISSUE_OVF_TRAP_EN
  logic trap_q;
  logic arith_q;
  assign trap_active = trap_q;
  assign OvfTrap     = trap_q;
`else
  assign trap_active = 1'b0;
`endif

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == FULL_CNT);
  assign RspValid = (count != '0);
  assign pop      = RspValid && RspReady;
  assign Busy     = (state_q != IDLE) || RspValid;

  // Illegal commands never touched the ALU, so their entry is synthesised here.
  assign push_data = illegal_q ? 20'h00001
                               : {AluResult, AluZero, AluOverflow, AluCarryOut, 1'b0};

  always_comb begin
    state_d  = state_q;
    CmdReady = 1'b0;
    accept   = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        CmdReady = !full && !trap_active;
        if (CmdValid && CmdReady) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = CAPTURE;
      CAPTURE: begin
        capture = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q    <= IDLE;
      illegal_q  <= 1'b0;
      AluA       <= '0;
      AluB       <= '0;
      AluOp      <= 4'b0000;
      AluAInvert <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        illegal_q <= !dec_legal;
        // Alu* keep the last legal issue so the ALU inputs never follow CmdA/CmdB.
        if (dec_legal) begin
          AluA       <= CmdA;
          AluB       <= CmdB;
          AluOp      <= dec_op;
          AluAInvert <= dec_inv;
        end
      end
    end
  end

`ifdef ALU_ISSUE_OVF_TRAP_EN
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      trap_q  <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      if (accept) arith_q <= (CmdOp == 3'd2) || (CmdOp == 3'd3);
      if (capture && arith_q && !illegal_q && AluOverflow) trap_q <= 1'b1;
    end
  end
`endif

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (capture) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({capture, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload reads as zero whenever nothing is presented, including after reset.
  always_comb begin
    RspResult   = '0;
    RspZero     = 1'b0;
    RspOverflow = 1'b0;
    RspCarryOut = 1'b0;
    RspIllegal  = 1'b0;
    if (RspValid) begin
      {RspResult, RspZero, RspOverflow, RspCarryOut, RspIllegal} = mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb/tb_alu_issue_unit.sv - directed and randomized self-checking bench for alu_issue_unit

module tb_alu_issue_unit;

  localparam int DEPTH = 2;

  logic        Clock, Reset;
  logic        CmdValid, CmdReady;
  logic [2:0]  CmdOp;
  logic [15:0] CmdA, CmdB;
  logic [15:0] AluA, AluB;
  logic        AluAInvert;
  logic [3:0]  AluOp;
  logic [15:0] AluResult;
  logic        AluZero, AluOverflow, AluCarryOut;
  logic        RspValid, RspReady;
  logic [15:0] RspResult;
  logic        RspZero, RspOverflow, RspCarryOut, RspIllegal;
  logic        Busy;
`ifdef ALU_ISSUE_OVF_TRAP_EN
  logic        OvfTrap;
`endif

  alu_issue_unit #(.RESP_DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset),
    .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdOp(CmdOp), .CmdA(CmdA), .CmdB(CmdB),
    .AluA(AluA), .AluB(AluB), .AluAInvert(AluAInvert), .AluOp(AluOp),
    .AluResult(AluResult), .AluZero(AluZero), .AluOverflow(AluOverflow), .AluCarryOut(AluCarryOut),
    .RspValid(RspValid), .RspReady(RspReady), .RspResult(RspResult), .RspZero(RspZero),
    .RspOverflow(RspOverflow), .RspCarryOut(RspCarryOut), .RspIllegal(RspIllegal),
`ifdef ALU_ISSUE_OVF_TRAP_EN
    .OvfTrap(OvfTrap),
`endif
    .Busy(Busy)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // External ALU: classic invert-A / negate-B adder-logic unit.
  logic [15:0] ea, eb;
  logic [16:0] esum;
  always_comb begin
    ea          = AluAInvert ? ~AluA : AluA;
    eb          = AluOp[3] ? ~AluB : AluB;
    esum        = {1'b0, ea} + {1'b0, eb} + {16'h0, AluOp[3]};
    AluResult   = 16'h0;
    AluCarryOut = 1'b0;
    AluOverflow = 1'b0;
    case (AluOp[2:0])
      3'b000: AluResult = ea & eb;
      3'b001: AluResult = ea | eb;
      3'b100: begin
        AluResult   = esum[15:0];
        AluCarryOut = esum[16];
        AluOverflow = (ea[15] == eb[15]) && (esum[15] != ea[15]);
      end
      default: AluResult = 16'h0;
    endcase
    AluZero = (AluResult == 16'h0);
  end

  typedef struct packed {
    logic [15:0] res;
    logic        z, v, c, ill;
  } rsp_t;

  int   n_cmp = 0;
  int   n_err = 0;
  rsp_t q[$];
  int   age = 3;
  logic [15:0] la = '0, lb = '0;
  logic [3:0]  lop = '0;
  logic        linv = 1'b0;
  bit   trap_m = 0, pend_trap = 0, last_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t ref_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    rsp_t r;
    logic [16:0] w;
    r = '0;
    case (op)
      3'd0: r.res = a & b;
      3'd1: r.res = a | b;
      3'd2: begin
        w     = {1'b0, a} + {1'b0, b};
        r.res = w[15:0];
        r.c   = w[16];
        r.v   = (a[15] == b[15]) && (r.res[15] != a[15]);
      end
      3'd3: begin
        r.res = a - b;
        r.c   = (a >= b);
        r.v   = (a[15] != b[15]) && (r.res[15] != a[15]);
      end
      3'd4: r.res = ~(a | b);
      default: r.ill = 1'b1;
    endcase
    if (!r.ill) r.z = (r.res == 16'h0);
    return r;
  endfunction

  function automatic logic [4:0] ctl_of(input logic [2:0] op);
    case (op)
      3'd0: return 5'b0000_0;
      3'd1: return 5'b0001_0;
      3'd2: return 5'b0100_0;
      3'd3: return 5'b1100_0;
      default: return 5'b1000_1;
    endcase
  endfunction

  // One clock: check against the model, advance through the edge, update the model.
  task automatic step();
    int occ;
    bit exp_rdy, acc, pop;
    occ     = q.size() - ((age < 2) ? 1 : 0);
    exp_rdy = (age >= 2) && (occ < DEPTH) && !trap_m;
    chk("cmd_ready", CmdReady, exp_rdy);
    chk("rsp_valid", RspValid, occ > 0);
    chk("busy", Busy, (age < 2) || (occ > 0));
    chk("alu_a", AluA, la);
    chk("alu_b", AluB, lb);
    chk("alu_ctl", {AluOp, AluAInvert}, {lop, linv});
    if (occ > 0)
      chk("rsp_payload", {RspResult, RspZero, RspOverflow, RspCarryOut, RspIllegal}, q[0]);
    acc = CmdValid && exp_rdy;
    pop = (occ > 0) && RspReady;
    last_acc = acc;
    @(posedge Clock);
    #1;
    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back(ref_model(CmdOp, CmdA, CmdB));
      age = 0;
      if (CmdOp <= 3'd4) begin
        la = CmdA;
        lb = CmdB;
        {lop, linv} = ctl_of(CmdOp);
      end
`ifdef ALU_ISSUE_OVF_TRAP_EN
      pend_trap = (CmdOp == 3'd2 || CmdOp == 3'd3) && q[q.size()-1].v;
`endif
    end else if (age < 3) begin
      age++;
      if (age == 2 && pend_trap) trap_m = 1;
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    CmdValid = 1'b1;
    CmdOp    = op;
    CmdA     = a;
    CmdB     = b;
    last_acc = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (last_acc) break;
    end
    chk("send_accepted", last_acc, 1'b1);
    CmdValid = 1'b0;
  endtask

  task automatic drain();
    RspReady = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0) break;
      step();
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    Reset    = 1'b0;
    CmdValid = 1'b0;
    @(posedge Clock);
    #1;
    q.delete();
    age = 3; la = '0; lb = '0; lop = '0; linv = 1'b0;
    trap_m = 0; pend_trap = 0;
    chk("rst_rsp_valid", RspValid, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_cmd_ready", CmdReady, 1'b1);
    chk("rst_payload", {RspResult, RspZero, RspOverflow, RspCarryOut, RspIllegal}, 20'h0);
    chk("rst_alu", {AluA, AluB, AluOp, AluAInvert}, 37'h0);
    Reset = 1'b1;
  endtask

  initial begin
    Reset = 1'b0; CmdValid = 1'b0; CmdOp = '0; CmdA = '0; CmdB = '0; RspReady = 1'b1;
    @(posedge Clock);
    #1;
    do_reset();

    // ADD 10+10: response two edges after accept
    send(3'd2, 16'd10, 16'd10);
    step();
    chk("add_not_yet", RspValid, 1'b0);
    step();
    chk("add_valid", RspValid, 1'b1);
    chk("add_result", {RspResult, RspZero, RspOverflow}, {16'd20, 2'b00});
    step();

    // SUB 10-10
    send(3'd3, 16'd10, 16'd10);
    chk("sub_aluop", AluOp, 4'b1100);
    step(); step();
    chk("sub_result", {RspResult, RspZero, RspCarryOut}, {16'h0, 2'b11});
    step();

    // NOR
    send(3'd4, 16'h00FF, 16'h0F0F);
    chk("nor_ctl", {AluAInvert, AluOp}, 5'b1_1000);
    step(); step();
    chk("nor_result", RspResult, 16'hF000);
    drain();

    // Back-pressure: third command held while the buffer is full
    RspReady = 1'b0;
    send(3'd2, 16'd1, 16'd2);
    send(3'd0, 16'hF0F0, 16'h3C3C);
    CmdValid = 1'b1; CmdOp = 3'd1; CmdA = 16'h1234; CmdB = 16'h4321;
    for (int i = 0; i < 6; i++) step();
    chk("full_hold_ready", CmdReady, 1'b0);
    chk("full_hold_count", q.size(), DEPTH);
    RspReady = 1'b1;
    send(3'd1, 16'h1234, 16'h4321);
    drain();

    // Signed overflow
    send(3'd2, 16'h7FFF, 16'h0001);
    step(); step();
    chk("ovf_result", {RspResult, RspOverflow}, {16'h8000, 1'b1});
    drain();
`ifdef ALU_ISSUE_OVF_TRAP_EN
    for (int i = 0; i < 3; i++) step();
    chk("ovf_trap", OvfTrap, 1'b1);
    chk("ovf_trap_ready", CmdReady, 1'b0);
    do_reset();
    chk("ovf_trap_cleared", OvfTrap, 1'b0);
`endif

    // Reset during CAPTURE with one buffered response
    RspReady = 1'b0;
    send(3'd2, 16'd1, 16'd2);
    step(); step();
    send(3'd3, 16'd5, 16'd3);
    step();
    do_reset();

    // Illegal opcode after reset
    RspReady = 1'b1;
    send(3'd6, 16'hABCD, 16'h1111);
    step(); step();
    chk("illegal_rsp", {RspValid, RspResult, RspIllegal, RspZero}, {1'b1, 16'h0, 1'b1, 1'b0});
    drain();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [15:0] pick [4];
      pick[0] = 16'h0000; pick[1] = 16'hFFFF; pick[2] = 16'h7FFF; pick[3] = 16'h8000;
      CmdValid = ($urandom_range(0, 2) != 0);
      CmdOp    = 3'($urandom_range(0, 7));
      CmdA     = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
      CmdB     = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
      RspReady = ($urandom_range(0, 3) != 0);
      step();
    end
    CmdValid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 Parameter: RESP_DEPTH, default 2, response buffer entries (legal values 1..4).
REQ-002 Clock  input  1  rising-edge clock, single domain.
REQ-003 Reset  input  1  synchronous, active-low reset.
REQ-004 CmdValid  input  1  command offered.
REQ-005 CmdReady  output  1  command accepted when CmdValid&&CmdReady at Clock edge.
REQ-006 CmdOp  input  3  0=AND, 1=OR, 2=ADD, 3=SUB, 4=NOR, 5..7 illegal.
REQ-007 CmdA, CmdB  input  16  operands.
REQ-008 AluA, AluB  output  16  operands driven to the combinational ALU.
REQ-009 AluAInvert  output  1; AluOp  output  4  ALU control (Op[3]=B negate/carry-in, Op[2:0]=select).
REQ-010 AluResult  input  16; AluZero, AluOverflow, AluCarryOut  input  1  ALU outputs.
REQ-011 RspValid  output  1; RspReady  input  1  response handshake.
REQ-012 RspResult  output  16; RspZero, RspOverflow, RspCarryOut, RspIllegal  output  1  response payload.
REQ-013 Busy  output  1  high whenever state is not IDLE or buffer non-empty.

Function
REQ-014 Decode SHALL be: AND Op=0000 AInv=0; OR Op=0001 AInv=0; ADD Op=0100 AInv=0; SUB Op=1100 AInv=0; NOR Op=1000 AInv=1.
REQ-015 FSM states SHALL be IDLE, ISSUE, CAPTURE.
REQ-016 IDLE: CmdReady=1 iff buffer not full; on accept, command registered, next state ISSUE.
REQ-017 ISSUE: registered operands/control SHALL drive Alu* ports for exactly one cycle of settling; next CAPTURE.
REQ-018 CAPTURE: AluResult and flags SHALL be written to buffer tail at the edge ending this cycle; next IDLE.
REQ-019 Alu* outputs SHALL hold last issued values in IDLE (no glitch-driving from CmdA/CmdB).
REQ-020 Latency: accept edge N -> RspValid high after edge N+2 when buffer was empty; throughput 1 command per 3 cycles.
REQ-021 Illegal CmdOp SHALL be accepted, skip ALU (ISSUE->CAPTURE unchanged), write Result=0, flags=0, RspIllegal=1.
REQ-022 Buffer SHALL be FIFO of RESP_DEPTH entries; head presented on Rsp*; pop on RspValid&&RspReady.
REQ-023 Full: CmdReady=0 in IDLE; no command lost or overwritten.
REQ-024 Simultaneous push (CAPTURE) and pop SHALL be legal at any occupancy including full-with-pop; count unchanged.
REQ-025 Pointers SHALL wrap modulo RESP_DEPTH.
REQ-026 RspValid/payload SHALL remain stable while RspValid&&!RspReady.
REQ-027 CmdReady SHALL be 0 in ISSUE and CAPTURE.

Reset
REQ-028 Reset low at an edge SHALL force IDLE, empty buffer, CmdReady=1 next cycle, RspValid=0, all Rsp* payload 0, AluA=AluB=0, AluOp=0000, AluAInvert=0, Busy=0.
REQ-029 Reset mid-ISSUE/CAPTURE SHALL discard the in-flight command and all buffered responses.
REQ-030 Reset SHALL take priority over every handshake in the same cycle.

Configuration
REQ-031 Macro ALU_ISSUE_OVF_TRAP_EN: when defined, ADD/SUB capturing AluOverflow=1 SHALL set a sticky output OvfTrap (1 bit) and CmdReady SHALL stay 0 until Reset; response still enqueued.
REQ-032 Without ALU_ISSUE_OVF_TRAP_EN, port OvfTrap SHALL not exist and overflow is only reported via RspOverflow.

Verification
REQ-033 ADD A=10,B=10, RspReady=1 -> RspResult=20, Zero=0, Ovf=0, RspValid 2 edges after accept.
REQ-034 SUB A=10,B=10 -> AluOp=1100, RspResult=0, RspZero=1, RspCarryOut=1.
REQ-035 NOR A=16'h00FF,B=16'h0F0F -> AluAInvert=1, AluOp=1000, RspResult=16'hF000.
REQ-036 RspReady=0, three commands (depth 2) -> third held with CmdReady=0; release RspReady -> responses in order, no loss.
REQ-037 ADD 16'h7FFF+1 -> RspOverflow=1, result 16'h8000; with macro OvfTrap=1 and CmdReady stuck 0 until Reset.
REQ-038 Reset asserted during CAPTURE with one buffered response -> next cycle RspValid=0, state IDLE, no response emitted; CmdOp=6 afterwards -> RspIllegal=1, Result=0.
